// File: rtl/bitrev_gather_if.sv
// Stream bundle for bitrev_gather: input beat handshake, output beat handshake
// and the input beat index.
//   master : drives in_valid/in_data/out_ready, observes the rest (testbench side)
//   slave  : the gather block itself
interface bitrev_gather_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W*LANES-1:0]  in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W*LANES-1:0]  out_data;
  logic                     out_last;
  logic [3:0]               in_beat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, in_beat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, in_beat
  );
endinterface

// File: rtl/bitrev_gather.sv
// bitrev_gather: reorders a 512-coefficient frame (16 beats x 32 lanes) from
// bit-reversed input order into natural output order.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : bitrev_gather_if.slave
//           in_valid/in_ready/in_data    input beat handshake
//           out_valid/out_ready/out_data output beat handshake, out_last on beat 15
//           in_beat                      index of next input beat in the frame
// Build option: define BITREV_GATHER_PINGPONG_EN for two banks (fill one while
// draining the other); otherwise a single bank alternates fill and drain.
module bitrev_gather #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 32
) (
  input  logic          clk,
  input  logic          reset,
  bitrev_gather_if.slave bus
);

`ifdef BITREV_GATHER_PINGPONG_EN
  localparam int unsigned NB = 2;
`else
  localparam int unsigned NB = 1;
`endif
  localparam int unsigned BEATS     = 16;
  localparam logic [3:0]  LAST_BEAT = 4'd15;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  bank_state_e state_q [NB];
  bank_state_e state_d [NB];
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic [3:0]  in_beat_q, in_beat_d;
  logic [3:0]  out_beat_q, out_beat_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        in_acc_c, out_xfer_c;

  logic [DATA_W-1:0]       mem_q [NB][BEATS][LANES];
  logic [DATA_W*LANES-1:0] out_data_c;

  // Input lane n of any beat lands in output row bitrev5(n)>>1.
  function automatic logic [3:0] dst_row(input logic [4:0] n);
    return {n[0], n[1], n[2], n[3]};
  endfunction

  // Output lane: low bit of bitrev5(n) above bitrev4(b).
  function automatic logic [4:0] dst_lane(input logic [4:0] n, input logic [3:0] b);
    return {n[4], b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic next_bank(input logic b);
    return (NB == 2) ? ~b : 1'b0;
  endfunction

  assign in_acc_c   = bus.in_valid & in_ready_q;
  assign out_xfer_c = out_valid_q & bus.out_ready;

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NB; i++) state_q[i] <= BANK_EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      in_beat_q   <= 4'd0;
      out_beat_q  <= 4'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      in_beat_q   <= in_beat_d;
      out_beat_q  <= out_beat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Bank state transitions and beat counters.
  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    in_beat_d  = in_beat_q;
    out_beat_d = out_beat_q;
    if (in_acc_c) begin
      in_beat_d = in_beat_q + 4'd1;
      if (state_q[wr_bank_q] == BANK_EMPTY) state_d[wr_bank_q] = BANK_FILLING;
      if (in_beat_q == LAST_BEAT) begin
        state_d[wr_bank_q] = BANK_FULL;
        wr_bank_d          = next_bank(wr_bank_q);
      end
    end
    // Fill and drain never target the same bank, so both may act in one cycle.
    if (out_xfer_c) begin
      out_beat_d = out_beat_q + 4'd1;
      if (out_beat_q == LAST_BEAT) begin
        state_d[rd_bank_q] = BANK_EMPTY;
        rd_bank_d          = next_bank(rd_bank_q);
      end
    end
  end

  // Next values of the registered handshake outputs, taken from next state.
  always_comb begin
    in_ready_d  = (state_d[wr_bank_d] != BANK_FULL);
    out_valid_d = (state_d[rd_bank_d] == BANK_FULL);
    out_last_d  = out_valid_d && (out_beat_d == LAST_BEAT);
  end

  // Scatter each accepted beat into natural-order positions; storage is unreset.
  always_ff @(posedge clk) begin
    if (in_acc_c) begin
      for (int unsigned n = 0; n < LANES; n++) begin
        mem_q[wr_bank_q][dst_row(5'(n))][dst_lane(5'(n), in_beat_q)] <=
          bus.in_data[DATA_W*n +: DATA_W];
      end
    end
  end

  // Output row read from the draining bank; zero whenever nothing is presented.
  always_comb begin
    out_data_c = '0;
    if (out_valid_q) begin
      for (int unsigned m = 0; m < LANES; m++) begin
        out_data_c[DATA_W*m +: DATA_W] = mem_q[rd_bank_q][out_beat_q][m];
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.in_beat   = in_beat_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_c;

endmodule

// File: tb/tb_bitrev_gather.sv
module tb_bitrev_gather;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 32;
  localparam int unsigned BW     = DATA_W * LANES;
  typedef logic [BW-1:0] beat_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  bitrev_gather_if #(.DATA_W(DATA_W), .LANES(LANES)) bus ();
  bitrev_gather #(.DATA_W(DATA_W), .LANES(LANES)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  int lows    = 0;

  beat_t frame_buf [16];
  beat_t exp_d_q [$];
  bit    exp_l_q [$];
  int    xfer_cyc [$];

  beat_t mon_d;
  bit    mon_l;
  int    mon_bad;

  always @(posedge clk) cyc++;

  function automatic logic [8:0] bitrev9(input logic [8:0] x);
    logic [8:0] r;
    for (int i = 0; i < 9; i++) r[i] = x[8-i];
    return r;
  endfunction

  function automatic beat_t rand_beat();
    beat_t v;
    for (int l = 0; l < int'(LANES); l++) v[DATA_W*l +: DATA_W] = DATA_W'($urandom);
    return v;
  endfunction

  task automatic fill_index();
    for (int b = 0; b < 16; b++)
      for (int n = 0; n < int'(LANES); n++)
        frame_buf[b][DATA_W*n +: DATA_W] = DATA_W'(32*b + n);
  endtask

  task automatic fill_random();
    for (int b = 0; b < 16; b++) frame_buf[b] = rand_beat();
  endtask

  // Model: flat input index i sits at natural position bitrev9(i).
  task automatic push_expected();
    beat_t e [16];
    logic [8:0] k;
    for (int i = 0; i < 512; i++) begin
      k = bitrev9(9'(i));
      e[k[8:5]][DATA_W*int'(k[4:0]) +: DATA_W] = frame_buf[i/32][DATA_W*(i%32) +: DATA_W];
    end
    for (int r = 0; r < 16; r++) begin
      exp_d_q.push_back(e[r]);
      exp_l_q.push_back(r == 15);
    end
  endtask

  task automatic send_beat(input beat_t d);
    bit rdy;
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    forever begin
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) break;
      guard++;
      if (guard > 100) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: in_ready stayed %0b, required 1 within 100 cycles", bus.in_ready);
        break;
      end
      @(negedge clk);
    end
    #1;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    bus.in_data  = rand_beat();
  endtask

  task automatic send_frame();
    for (int b = 0; b < 16; b++) send_beat(frame_buf[b]);
  endtask

  task automatic wait_drain(input int budget);
    int g;
    g = 0;
    while (exp_d_q.size() != 0 && g < budget) begin
      @(posedge clk); #2;
      g++;
    end
    n_tests++;
    if (exp_d_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d beats still pending, required 0", exp_d_q.size());
    end
  endtask

  // Scoreboard: every output transfer must match the next queued beat.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      xfer_cyc.push_back(cyc + 1);
      n_tests++;
      if (exp_d_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got beat lane0 %h, required no beat", bus.out_data[DATA_W-1:0]);
      end else begin
        mon_d = exp_d_q.pop_front();
        mon_l = exp_l_q.pop_front();
        if (bus.out_data !== mon_d) begin
          mon_bad = 0;
          for (int l = int'(LANES) - 1; l >= 0; l--)
            if (bus.out_data[DATA_W*l +: DATA_W] !== mon_d[DATA_W*l +: DATA_W]) mon_bad = l;
          n_fail++;
          $display("FAIL sb_out_data: lane %0d got %h, required %h", mon_bad,
                   bus.out_data[DATA_W*mon_bad +: DATA_W], mon_d[DATA_W*mon_bad +: DATA_W]);
        end
        n_tests++;
        if (bus.out_last !== mon_l) begin
          n_fail++;
          $display("FAIL sb_out_last: got %0b, required %0b", bus.out_last, mon_l);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b, required 0", bus.out_valid); end
    n_tests++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %0b, required 0", bus.out_last); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %0b, required 0", bus.in_ready); end
    n_tests++; if (bus.in_beat !== 4'd0) begin n_fail++; $display("FAIL reset_in_beat: got %0d, required 0", bus.in_beat); end
    n_tests++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got lane0 %h, required 0", bus.out_data[DATA_W-1:0]); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_pre_edge: got %0b, required 0", bus.in_ready); end
    @(posedge clk); #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_post_edge: got %0b, required 1", bus.in_ready); end
  endtask

  task automatic test_ordering();
    bus.out_ready = 1'b1;
    fill_index();
    push_expected();
    send_frame();
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL order_valid_latency: got %0b, required 1", bus.out_valid); end
    n_tests++; if (bus.out_data[DATA_W +: DATA_W] !== DATA_W'(256)) begin n_fail++; $display("FAIL order_b0_l1: got %0d, required 256", bus.out_data[DATA_W +: DATA_W]); end
    repeat (8) @(negedge clk);
    n_tests++; if (bus.out_data[DATA_W-1:0] !== DATA_W'(1)) begin n_fail++; $display("FAIL order_b8_l0: got %0d, required 1", bus.out_data[DATA_W-1:0]); end
    wait_drain(100);
  endtask

  task automatic test_gaps();
    bus.out_ready = 1'b1;
    fill_random();
    push_expected();
    for (int b = 0; b < 16; b++) begin
      send_beat(frame_buf[b]);
      @(negedge clk);
      n_tests++; if (bus.in_beat !== 4'(b + 1)) begin n_fail++; $display("FAIL gap_in_beat: got %0d, required %0d", bus.in_beat, (b + 1) % 16); end
      @(negedge clk);
      n_tests++; if (bus.in_beat !== 4'(b + 1)) begin n_fail++; $display("FAIL gap_in_beat_idle: got %0d, required %0d", bus.in_beat, (b + 1) % 16); end
    end
    wait_drain(100);
  endtask

  task automatic test_backpressure();
    beat_t d0;
    logic  l0;
    @(posedge clk); #1 bus.out_ready = 1'b0;
    fill_random(); push_expected(); send_frame();
`ifdef BITREV_GATHER_PINGPONG_EN
    fill_random(); push_expected(); send_frame();
`endif
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0b, required 0", bus.in_ready); end
    n_tests++; if (bus.in_beat !== 4'd0) begin n_fail++; $display("FAIL bp_in_beat: got %0d, required 0", bus.in_beat); end
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %0b, required 1", bus.out_valid); end
    d0 = bus.out_data;
    l0 = bus.out_last;
    repeat (5) @(negedge clk);
    n_tests++; if (bus.out_data !== d0) begin n_fail++; $display("FAIL bp_hold_data: lane0 got %h, required %h", bus.out_data[DATA_W-1:0], d0[DATA_W-1:0]); end
    n_tests++; if (bus.out_last !== l0) begin n_fail++; $display("FAIL bp_hold_last: got %0b, required %0b", bus.out_last, l0); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_held: got %0b, required 0", bus.in_ready); end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_drain(100);
  endtask

`ifdef BITREV_GATHER_PINGPONG_EN
  task automatic test_back_to_back();
    int first_acc, a15;
    xfer_cyc.delete();
    bus.out_ready = 1'b1;
    fill_index(); push_expected();
    send_beat(frame_buf[0]);
    first_acc = acc_cyc;
    for (int b = 1; b < 16; b++) send_beat(frame_buf[b]);
    a15 = acc_cyc;
    fill_random(); push_expected(); send_frame();
    fill_random(); push_expected(); send_frame();
    n_tests++; if (acc_cyc - first_acc !== 47) begin n_fail++; $display("FAIL b2b_in_span: got %0d, required 47", acc_cyc - first_acc); end
    wait_drain(200);
    n_tests++;
    if (xfer_cyc.size() !== 48) begin
      n_fail++; $display("FAIL b2b_count: got %0d, required 48", xfer_cyc.size());
    end else begin
      n_tests++; if (xfer_cyc[0] !== a15 + 1) begin n_fail++; $display("FAIL b2b_first_out: got cycle %0d, required %0d", xfer_cyc[0], a15 + 1); end
      n_tests++; if (xfer_cyc[47] - xfer_cyc[0] !== 47) begin n_fail++; $display("FAIL b2b_out_span: got %0d, required 47", xfer_cyc[47] - xfer_cyc[0]); end
    end
  endtask
`else
  task automatic test_single_bank();
    int first_acc;
    xfer_cyc.delete();
    bus.out_ready = 1'b1;
    fill_random(); push_expected();
    send_beat(frame_buf[0]);
    first_acc = acc_cyc;
    for (int b = 1; b < 16; b++) send_beat(frame_buf[b]);
    fill_random(); push_expected();
    lows = 0;
    fork
      send_frame();
      begin
        for (int g = 0; g < 40; g++) begin
          @(negedge clk);
          if (bus.in_ready === 1'b0) lows++;
          else break;
        end
      end
    join
    n_tests++; if (lows !== 16) begin n_fail++; $display("FAIL sb1_ready_low: got %0d cycles, required 16", lows); end
    wait_drain(100);
    n_tests++;
    if (xfer_cyc.size() !== 32) begin
      n_fail++; $display("FAIL sb1_count: got %0d, required 32", xfer_cyc.size());
    end else begin
      n_tests++; if (xfer_cyc[31] - first_acc !== 63) begin n_fail++; $display("FAIL sb1_span: got %0d, required 63", xfer_cyc[31] - first_acc); end
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    bus.out_ready = 1'b1;
    fill_random();
    for (int b = 0; b < 7; b++) send_beat(frame_buf[b]);
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %0b, required 0", bus.out_valid); end
    n_tests++; if (bus.in_beat !== 4'd0) begin n_fail++; $display("FAIL rst_mid_in_beat: got %0d, required 0", bus.in_beat); end
    @(posedge clk); #1 reset = 1'b0;
    bus.out_ready = 1'b0;
    fill_random();
    send_frame();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stored_out_valid: got %0b, required 0", bus.out_valid); end
    n_tests++; if (bus.in_beat !== 4'd0) begin n_fail++; $display("FAIL rst_stored_in_beat: got %0d, required 0", bus.in_beat); end
    fill_random(); push_expected(); send_frame();
    wait_drain(100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_ordering();
    test_gaps();
    test_backpressure();
`ifdef BITREV_GATHER_PINGPONG_EN
    test_back_to_back();
`else
    test_single_bank();
`endif
    test_reset_mid_frame();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
